// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel collector with a one-word holding register.
// The word consumer and the bit producer are decoupled by a valid/ready handshake.
module serial_to_parallel #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [IDX_W-1:0] bit_index,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  // The final bit goes straight into data_out, so only WIDTH-1 positions are stored.
  logic [WIDTH-2:0] shift;
  logic             last;
  logic             accept;

  assign last      = (bit_index == LAST);
  assign bit_ready = !(last && data_valid && !data_ready);
  assign accept    = bit_valid && bit_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_index  <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (clear) begin
      bit_index  <= '0;
      shift      <= '0;
      data_valid <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < WIDTH - 1; k++)
          if (bit_index == IDX_W'(k)) shift[k] <= bit_in;
        bit_index <= last ? '0 : IDX_W'(bit_index + 1'b1);
      end
      // A completing word wins over a consume on the same edge: no bubble.
      if (accept && last) begin
        data_out   <= {bit_in, shift};
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
